// File: rtl/z80_bus_pads_if.sv
// Signal bundle between the tv80s core wrapper and the mprj_io pins.
// The controller uses the master view; the core and the pins see the slave view.
interface z80_bus_pads_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              core_reset_n;
  logic              core_wait_n;
  logic              core_int_n;
  logic              core_nmi_n;
  logic              core_busrq_n;
  logic [ADDR_W-1:0] core_A;
  logic [DATA_W-1:0] core_dout;
  logic              core_doe;
  logic [DATA_W-1:0] core_di;
  logic              core_mreq_n;
  logic              core_iorq_n;
  logic              core_rd_n;
  logic              core_wr_n;
  logic              core_m1_n;
  logic              core_rfsh_n;
  logic              core_halt_n;
  logic              core_busak_n;
  logic              pad_wait_n;
  logic              pad_int_n;
  logic              pad_nmi_n;
  logic              pad_busrq_n;
  logic [DATA_W-1:0] pad_d_in;
  logic [ADDR_W-1:0] pad_a_out;
  logic [ADDR_W-1:0] pad_a_oeb;
  logic [DATA_W-1:0] pad_d_out;
  logic [DATA_W-1:0] pad_d_oeb;
  logic [3:0]        pad_ts_out;
  logic [3:0]        pad_ts_oeb;
  logic [3:0]        pad_st_out;

  // No valid/ready handshake: every strobe is a level, sampled on each clock edge.
  modport master (
    input  core_A, core_dout, core_doe,
    input  core_mreq_n, core_iorq_n, core_rd_n, core_wr_n,
    input  core_m1_n, core_rfsh_n, core_halt_n, core_busak_n,
    input  pad_wait_n, pad_int_n, pad_nmi_n, pad_busrq_n, pad_d_in,
    output core_reset_n, core_wait_n, core_int_n, core_nmi_n, core_busrq_n, core_di,
    output pad_a_out, pad_a_oeb, pad_d_out, pad_d_oeb,
    output pad_ts_out, pad_ts_oeb, pad_st_out
  );

  modport slave (
    output core_A, core_dout, core_doe,
    output core_mreq_n, core_iorq_n, core_rd_n, core_wr_n,
    output core_m1_n, core_rfsh_n, core_halt_n, core_busak_n,
    output pad_wait_n, pad_int_n, pad_nmi_n, pad_busrq_n, pad_d_in,
    input  core_reset_n, core_wait_n, core_int_n, core_nmi_n, core_busrq_n, core_di,
    input  pad_a_out, pad_a_oeb, pad_d_out, pad_d_oeb,
    input  pad_ts_out, pad_ts_oeb, pad_st_out
  );
endinterface

// File: rtl/z80_bus_pads.sv
// Pad-side bus controller for the z80 core: reset stretch, input synchronisers,
// bus float on reset/BUSAK with a turnaround gap, and memory/IO wait-state insertion.
module z80_bus_pads #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 3,
  parameter int TURN_CYCLES  = 1,
  parameter int WS_W         = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WS_W-1:0] cfg_mem_ws,
  input  logic [WS_W-1:0] cfg_io_ws,
  output logic [1:0]      bus_state,
  z80_bus_pads_if.master  bus
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_FLOAT = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam logic [3:0] RST_LAST  = 4'(RESET_CYCLES - 1);
  localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

  state_t          state;
  logic [3:0]      rst_cnt;
  logic [2:0]      turn_cnt;
  logic [WS_W-1:0] ws_cnt;
  logic            mreq_q;
  logic            iorq_q;
  logic            mreq_fall;
  logic            iorq_fall;
  logic [3:0]      async_raw;
  logic [3:0]      async_sync;

  assign async_raw = {bus.pad_busrq_n, bus.pad_nmi_n, bus.pad_int_n, bus.pad_wait_n};

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign async_sync = async_raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][3:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= async_raw;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign async_sync = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign bus.core_wait_n  = async_sync[0] & (ws_cnt == '0);
  assign bus.core_int_n   = async_sync[1];
  assign bus.core_nmi_n   = async_sync[2];
  assign bus.core_busrq_n = async_sync[3];
  assign bus.core_di      = bus.pad_d_in;
  assign bus_state        = state;

  assign mreq_fall = mreq_q & ~bus.core_mreq_n;
  assign iorq_fall = iorq_q & ~bus.core_iorq_n;

  // Refresh cycles never wait; an interrupt acknowledge (M1 with IORQ) loads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_cnt <= '0;
      mreq_q <= 1'b1;
      iorq_q <= 1'b1;
    end else begin
      mreq_q <= bus.core_mreq_n;
      iorq_q <= bus.core_iorq_n;
      if (state != S_RUN)                 ws_cnt <= '0;
      else if (mreq_fall && bus.core_rfsh_n) ws_cnt <= cfg_mem_ws;
      else if (iorq_fall)                 ws_cnt <= bus.core_m1_n ? cfg_io_ws : '0;
      else if (ws_cnt != '0)              ws_cnt <= ws_cnt - WS_W'(1);
    end
  end

  // Pad enables follow the state held before the edge, so every enable change
  // lands one clock after the state change that causes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_RESET;
      rst_cnt          <= '0;
      turn_cnt         <= '0;
      bus.core_reset_n <= 1'b0;
      bus.pad_a_out    <= '0;
      bus.pad_a_oeb    <= '1;
      bus.pad_d_out    <= '0;
      bus.pad_d_oeb    <= '1;
      bus.pad_ts_out   <= 4'hF;
      bus.pad_ts_oeb   <= 4'hF;
      bus.pad_st_out   <= 4'hF;
    end else begin
      bus.pad_a_out  <= bus.core_A;
      bus.pad_d_out  <= bus.core_dout;
      bus.pad_ts_out <= {bus.core_wr_n, bus.core_rd_n, bus.core_iorq_n, bus.core_mreq_n};
      bus.pad_st_out <= {bus.core_busak_n, bus.core_halt_n, bus.core_rfsh_n, bus.core_m1_n};
      bus.pad_a_oeb  <= (state == S_RUN) ? '0 : '1;
      bus.pad_d_oeb  <= (state == S_RUN) ? {DATA_W{~bus.core_doe}} : '1;
      bus.pad_ts_oeb <= (state == S_RUN) ? 4'h0 : 4'hF;
      case (state)
        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state            <= S_RUN;
            bus.core_reset_n <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        S_RUN: begin
          if (!bus.core_busak_n) state <= S_FLOAT;
        end
        S_FLOAT: begin
          turn_cnt <= '0;
          if (bus.core_busak_n) state <= (TURN_CYCLES == 0) ? S_RUN : S_TURN;
        end
        S_TURN: begin
          if (!bus.core_busak_n) begin
            state    <= S_FLOAT;
            turn_cnt <= '0;
          end else if (turn_cnt == TURN_LAST) begin
            state    <= S_RUN;
            turn_cnt <= '0;
          end else begin
            turn_cnt <= turn_cnt + 3'd1;
          end
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_pads.sv
// Directed bench for z80_bus_pads: reset stretch, synchroniser latency, data enable,
// wait-state insertion, bus float/turnaround and asynchronous reset mid-write.
module tb_z80_bus_pads;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WS_W   = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [WS_W-1:0] cfg_mem_ws;
  logic [WS_W-1:0] cfg_io_ws;
  logic [1:0]      bus_state;
  logic [1:0]      bus_state0;
  int              checks = 0;
  int              errors = 0;
  logic [7:0]      exp_q[$];

  z80_bus_pads_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
  z80_bus_pads_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

  z80_bus_pads #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2),
    .RESET_CYCLES(3), .TURN_CYCLES(1), .WS_W(WS_W)
  ) u_dut (
    .clk(clk), .reset(reset), .cfg_mem_ws(cfg_mem_ws), .cfg_io_ws(cfg_io_ws),
    .bus_state(bus_state), .bus(bus)
  );

  z80_bus_pads #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(0),
    .RESET_CYCLES(3), .TURN_CYCLES(1), .WS_W(WS_W)
  ) u_dut_nosync (
    .clk(clk), .reset(reset), .cfg_mem_ws(cfg_mem_ws), .cfg_io_ws(cfg_io_ws),
    .bus_state(bus_state0), .bus(bus0)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.core_A = '0;       bus.core_dout = '0;     bus.core_doe = 1'b0;
    bus.core_mreq_n = 1'b1; bus.core_iorq_n = 1'b1; bus.core_rd_n = 1'b1;
    bus.core_wr_n = 1'b1;   bus.core_m1_n = 1'b1;   bus.core_rfsh_n = 1'b1;
    bus.core_halt_n = 1'b1; bus.core_busak_n = 1'b1;
    bus.pad_wait_n = 1'b1;  bus.pad_int_n = 1'b1;   bus.pad_nmi_n = 1'b1;
    bus.pad_busrq_n = 1'b1; bus.pad_d_in = '0;
    bus0.core_A = '0;       bus0.core_dout = '0;    bus0.core_doe = 1'b0;
    bus0.core_mreq_n = 1'b1; bus0.core_iorq_n = 1'b1; bus0.core_rd_n = 1'b1;
    bus0.core_wr_n = 1'b1;   bus0.core_m1_n = 1'b1;   bus0.core_rfsh_n = 1'b1;
    bus0.core_halt_n = 1'b1; bus0.core_busak_n = 1'b1;
    bus0.pad_wait_n = 1'b1;  bus0.pad_int_n = 1'b1;   bus0.pad_nmi_n = 1'b1;
    bus0.pad_busrq_n = 1'b1; bus0.pad_d_in = '0;
  endtask

  // scoreboard: one queued core_wait_n value per clock
  task automatic expect_wait(input string tag);
    while (exp_q.size() > 0) begin
      tick(1);
      check(tag, {31'd0, bus.core_wait_n}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_mem_ws = 3'd3;
    cfg_io_ws  = 3'd5;
    drive_idle();
    bus.core_A = 16'h1234;

    // reset held for 4 clocks
    tick(4);
    check("rst_core_reset_n", bus.core_reset_n, 1'b0);
    check("rst_state", bus_state, 2'd0);
    check("rst_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    check("rst_d_oeb", bus.pad_d_oeb, 8'hFF);
    check("rst_ts_oeb", bus.pad_ts_oeb, 4'hF);
    check("rst_ts_out", bus.pad_ts_out, 4'hF);
    check("rst_st_out", bus.pad_st_out, 4'hF);
    check("rst_a_out", bus.pad_a_out, 16'h0000);
    check("rst_wait_n", bus.core_wait_n, 1'b1);
    check("rst_int_n", bus.core_int_n, 1'b1);

    // reset stretch: core_reset_n rises on the 3rd edge after release
    reset = 1'b0;
    tick(1);
    check("stretch_e1", bus.core_reset_n, 1'b0);
    tick(1);
    check("stretch_e2", bus.core_reset_n, 1'b0);
    tick(1);
    check("stretch_e3", bus.core_reset_n, 1'b1);
    check("stretch_e3_state", bus_state, 2'd1);
    check("stretch_e3_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    tick(1);
    check("run_a_oeb", bus.pad_a_oeb, 16'h0000);
    check("run_ts_oeb", bus.pad_ts_oeb, 4'h0);
    check("run_d_oeb", bus.pad_d_oeb, 8'hFF);
    check("run_a_out", bus.pad_a_out, 16'h1234);

    // read data passes straight through
    bus.pad_d_in = 8'h3C;
    #1;
    check("core_di", bus.core_di, 8'h3C);

    // synchroniser latency: 2 stages vs bypass
    bus.pad_int_n  = 1'b0;
    bus0.pad_int_n = 1'b0;
    #1;
    check("int_bypass", bus0.core_int_n, 1'b0);
    check("int_sync_e0", bus.core_int_n, 1'b1);
    tick(1);
    check("int_sync_e1", bus.core_int_n, 1'b1);
    tick(1);
    check("int_sync_e2", bus.core_int_n, 1'b0);
    bus.pad_int_n  = 1'b1;
    bus0.pad_int_n = 1'b1;
    tick(2);

    // data enable follows core_doe one clock late
    bus.core_doe  = 1'b1;
    bus.core_dout = 8'hA5;
    tick(1);
    check("doe_1", bus.pad_d_oeb, 8'h00);
    check("dout", bus.pad_d_out, 8'hA5);
    bus.core_doe = 1'b0;
    tick(1);
    check("doe_0", bus.pad_d_oeb, 8'hFF);

    // memory cycle, 3 wait states
    bus.core_mreq_n = 1'b0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    expect_wait("mem_ws3");
    check("mem_ts_out", bus.pad_ts_out, 4'hE);
    bus.core_mreq_n = 1'b1;
    tick(1);

    // IO cycle, 5 wait states
    bus.core_iorq_n = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'd0);
    exp_q.push_back(8'd1);
    expect_wait("io_ws5");
    bus.core_iorq_n = 1'b1;
    tick(1);

    // refresh cycle: no waits
    bus.core_rfsh_n = 1'b0;
    bus.core_mreq_n = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd1); exp_q.push_back(8'd1);
    expect_wait("rfsh_ws");
    bus.core_mreq_n = 1'b1;
    bus.core_rfsh_n = 1'b1;
    tick(1);

    // interrupt acknowledge: no waits
    bus.core_m1_n   = 1'b0;
    bus.core_iorq_n = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd1);
    expect_wait("inta_ws");
    bus.core_iorq_n = 1'b1;
    bus.core_m1_n   = 1'b1;
    tick(1);

    // new config applies at the next strobe edge
    cfg_mem_ws = 3'd1;
    bus.core_mreq_n = 1'b0;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    expect_wait("mem_ws1");
    bus.core_mreq_n = 1'b1;
    tick(1);
    cfg_mem_ws = 3'd0;
    bus.core_mreq_n = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd1);
    expect_wait("mem_ws0");
    bus.core_mreq_n = 1'b1;
    tick(1);

    // bus request: busak_n low for 6 clocks
    bus.core_busak_n = 1'b0;
    tick(1);
    check("float_state", bus_state, 2'd2);
    check("float_st_out", bus.pad_st_out, 4'h7);
    tick(1);
    check("float_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    check("float_d_oeb", bus.pad_d_oeb, 8'hFF);
    check("float_ts_oeb", bus.pad_ts_oeb, 4'hF);
    tick(4);
    bus.core_busak_n = 1'b1;
    tick(1);
    check("turn_state", bus_state, 2'd3);
    check("turn_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    tick(1);
    check("back_run_state", bus_state, 2'd1);
    check("back_run_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    tick(1);
    check("redriven_a_oeb", bus.pad_a_oeb, 16'h0000);
    check("redriven_ts_oeb", bus.pad_ts_oeb, 4'h0);
    check("redriven_st_out", bus.pad_st_out, 4'hF);

    // busak reasserted during turnaround: no driven glitch
    bus.core_busak_n = 1'b0;
    tick(1);
    check("re_float_state", bus_state, 2'd2);
    tick(1);
    check("re_float_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    bus.core_busak_n = 1'b1;
    tick(1);
    check("re_turn_state", bus_state, 2'd3);
    bus.core_busak_n = 1'b0;
    tick(1);
    check("re_turn_abort_state", bus_state, 2'd2);
    check("re_turn_abort_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    tick(1);
    check("re_turn_hold_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    bus.core_busak_n = 1'b1;
    tick(2);
    check("re_run_state", bus_state, 2'd1);
    check("re_run_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    tick(1);
    check("re_run_driven", bus.pad_a_oeb, 16'h0000);

    // asynchronous reset in the middle of a write
    bus.core_doe  = 1'b1;
    bus.core_dout = 8'h5A;
    tick(1);
    check("write_d_oeb", bus.pad_d_oeb, 8'h00);
    #2;
    reset = 1'b1;
    #1;
    check("async_d_oeb", bus.pad_d_oeb, 8'hFF);
    check("async_a_oeb", bus.pad_a_oeb, 16'hFFFF);
    check("async_core_reset_n", bus.core_reset_n, 1'b0);
    check("async_state", bus_state, 2'd0);
    tick(2);
    reset = 1'b0;
    bus.core_doe = 1'b0;
    tick(2);
    check("restretch_e2", bus.core_reset_n, 1'b0);
    tick(1);
    check("restretch_e3", bus.core_reset_n, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
